// File: rtl/write_back_stage_if.sv
// Write-back stage bus: MEM/WB result input, hazard-unit query and
// register-bank write port, grouped so the stage and its driver share one
// signal list.
interface write_back_stage_if;
    // MEM/WB result handshake
    logic        in_valid;
    logic        in_ready;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic        mem_to_reg;
    logic [31:0] alu_result;
    logic [31:0] mem_data;
    logic [1:0]  load_size;
    logic        load_unsigned;
    logic [1:0]  byte_off;

    // Hazard-unit lookup of pending writes
    logic [4:0]  q_reg;
    logic        q_hit;
    logic [31:0] q_data;

    // Register-bank write port
    logic        reg_write;
    logic [4:0]  rw;
    logic [31:0] busw;
    logic        busy;

    // Producer side (pipeline / testbench)
    modport master (
        output in_valid, wb_en, wb_rd, mem_to_reg, alu_result, mem_data,
               load_size, load_unsigned, byte_off, q_reg,
        input  in_ready, q_hit, q_data, reg_write, rw, busw, busy
    );

    // Write-back stage side
    modport slave (
        input  in_valid, wb_en, wb_rd, mem_to_reg, alu_result, mem_data,
               load_size, load_unsigned, byte_off, q_reg,
        output in_ready, q_hit, q_data, reg_write, rw, busw, busy
    );
endinterface

// File: rtl/write_back_stage.sv
// MIPS-DLX write-back stage. Selects ALU or extended load data for each
// completed instruction, queues register writes, and replays them to the
// register bank with one cycle of rw/busw setup ahead of a one-cycle
// reg_write pulse (the bank captures on the rising edge of reg_write).
// Also answers the hazard unit's "is this register still pending" lookup.
module write_back_stage #(
    parameter int DEPTH = 2,   // pending-write queue entries, power of 2, >= 2
    parameter int AW    = 1    // log2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    write_back_stage_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2
    } state_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } entry_t;

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_C   = (AW+1)'(1);

    entry_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    state_t        state;
    logic          reg_write_q;
    logic [4:0]    rw_q;
    logic [31:0]   busw_q;

    logic          push;
    logic          pop;
    logic [31:0]   sel_data;
    entry_t        incoming;
    entry_t        head;
    entry_t        next_head;
    logic          more_after_pop;
    logic          q_hit_c;
    logic [31:0]   q_data_c;

    // Little-endian lane pick plus sign/zero extension of a load word.
    // byte_off[0] is irrelevant for halfword loads; size 11 behaves as word.
    function automatic logic [31:0] extend_load(
        input logic [31:0] word,
        input logic [1:0]  size,
        input logic        uns,
        input logic [1:0]  off
    );
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (size)
            2'b01:   extend_load = uns ? {16'h0000, h} : {{16{h[15]}}, h};
            2'b10:   extend_load = uns ? {24'h000000, b} : {{24{b[7]}}, b};
            default: extend_load = word;
        endcase
    endfunction

    // Result select at accept time; only committed into the queue on push.
    always_comb begin
        sel_data      = bus.mem_to_reg
                      ? extend_load(bus.mem_data, bus.load_size, bus.load_unsigned, bus.byte_off)
                      : bus.alu_result;
        incoming.rd   = bus.wb_rd;
        incoming.data = sel_data;
    end

    // A beat with wb_en=0 is consumed by the handshake but never queued.
    assign bus.in_ready = (count < DEPTH_C);
    assign push         = bus.in_valid & bus.in_ready & bus.wb_en;
    assign pop          = (state == STROBE);

    // Head and the entry that becomes head after the STROBE pop. With a single
    // entry left, the follower can only be the beat being pushed this cycle.
    always_comb begin
        head           = mem[rd_ptr];
        next_head      = (count > ONE_C) ? mem[rd_ptr + 1'b1] : incoming;
        more_after_pop = (count > ONE_C) || push;
    end

    // Queue pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Queue storage write.
    // NOTE: storage is not reset; count/pointers define validity, so stale
    // contents are never observed and the array can map onto plain flops/RAM.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= incoming;
    end

    // Bank-write sequencer: load rw/busw on entry to SETUP, pulse reg_write
    // for exactly the STROBE cycle, pop at the end of STROBE.
    // NOTE: all sequential state uses non-blocking assignment so every flop
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            reg_write_q <= 1'b0;
            rw_q        <= '0;
            busw_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    reg_write_q <= 1'b0;
                    if (count != '0) begin
                        rw_q   <= head.rd;
                        busw_q <= head.data;
                        state  <= SETUP;
                    end
                end
                SETUP: begin
                    reg_write_q <= 1'b1;
                    state       <= STROBE;
                end
                STROBE: begin
                    reg_write_q <= 1'b0;
                    if (more_after_pop) begin
                        rw_q   <= next_head.rd;
                        busw_q <= next_head.data;
                        state  <= SETUP;
                    end else begin
                        state  <= IDLE;
                    end
                end
                default: begin
                    reg_write_q <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

    // Hazard lookup over valid entries, oldest to youngest; youngest match wins.
    // NOTE: both outputs get defaults before the loop so no latch is inferred.
    always_comb begin
        q_hit_c  = 1'b0;
        q_data_c = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (((AW+1)'(i) < count) && (mem[rd_ptr + AW'(i)].rd == bus.q_reg)) begin
                q_hit_c  = 1'b1;
                q_data_c = mem[rd_ptr + AW'(i)].data;
            end
        end
    end

    assign bus.q_hit     = q_hit_c;
    assign bus.q_data    = q_data_c;
    assign bus.reg_write = reg_write_q;
    assign bus.rw        = rw_q;
    assign bus.busw      = busw_q;
    assign bus.busy      = (count != '0) || (state != IDLE);

endmodule

// File: tb/tb_write_back_stage.sv
// Directed self-checking bench for write_back_stage. Expected bank writes
// go into a scoreboard when a beat is accepted and are compared when the
// DUT raises reg_write.
module tb_write_back_stage;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   cyc;
    int   last_acc_cyc;
    exp_t sb[$];
    int   strobe_cyc[$];
    logic [4:0]  prev_rw;
    logic [31:0] prev_busw;

    write_back_stage_if bus_if ();

    write_back_stage #(.DEPTH(2), .AW(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Bank-write monitor: each reg_write cycle must match the oldest expected
    // write, and rw/busw must already have been stable the cycle before.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && bus_if.reg_write) begin
            check("strobe_expected", (sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("rw", bus_if.rw, e.rd);
                check("busw", bus_if.busw, e.data);
            end
            check("rw_setup", bus_if.rw, prev_rw);
            check("busw_setup", bus_if.busw, prev_busw);
            strobe_cyc.push_back(cyc);
        end
        prev_rw   = bus_if.rw;
        prev_busw = bus_if.busw;
    end

    // Present one beat and hold it until accepted; returns just after the accept edge.
    task automatic send(input logic en, input logic [4:0] rd, input logic m2r,
                        input logic [31:0] alu, input logic [31:0] mem_w,
                        input logic [1:0] size, input logic uns, input logic [1:0] off,
                        input logic [31:0] exp_data);
        logic rdy;
        bit   done;
        done = 0;
        rdy  = 0;
        @(negedge clk);
        bus_if.in_valid      = 1'b1;
        bus_if.wb_en         = en;
        bus_if.wb_rd         = rd;
        bus_if.mem_to_reg    = m2r;
        bus_if.alu_result    = alu;
        bus_if.mem_data      = mem_w;
        bus_if.load_size     = size;
        bus_if.load_unsigned = uns;
        bus_if.byte_off      = off;
        for (int k = 0; k < 50 && !done; k++) begin
            rdy = bus_if.in_ready;
            @(posedge clk);
            #1;
            if (rdy) done = 1;
        end
        if (done) begin
            if (en) sb.push_back('{rd, exp_data});
            last_acc_cyc = cyc;
        end else begin
            check("accept_timeout", rdy, 1);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        bus_if.in_valid = 1'b0;
    endtask

    // Wait (bounded) until the stage has drained.
    task automatic wait_idle();
        bit done;
        done = 0;
        for (int k = 0; k < 100 && !done; k++) begin
            @(posedge clk);
            #2;
            if (!bus_if.busy) done = 1;
        end
        if (!done) check("drain_timeout", bus_if.busy, 0);
        @(negedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int n;
        int acc;
        bit seen;
        checks = 0;
        errors = 0;
        cyc    = 0;
        prev_rw   = '0;
        prev_busw = '0;
        bus_if.in_valid      = 1'b0;
        bus_if.wb_en         = 1'b0;
        bus_if.wb_rd         = '0;
        bus_if.mem_to_reg    = 1'b0;
        bus_if.alu_result    = '0;
        bus_if.mem_data      = '0;
        bus_if.load_size     = '0;
        bus_if.load_unsigned = 1'b0;
        bus_if.byte_off      = '0;
        bus_if.q_reg         = 5'd31;

        // Reset state
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_reg_write", bus_if.reg_write, 0);
        check("rst_rw", bus_if.rw, 0);
        check("rst_busw", bus_if.busw, 0);
        check("rst_q_hit", bus_if.q_hit, 0);
        check("rst_q_data", bus_if.q_data, 0);
        check("rst_busy", bus_if.busy, 0);
        check("rst_in_ready", bus_if.in_ready, 1);
        #1 reset = 1'b0;

        // Single ALU write: setup one cycle after accept, pulse the next
        send(1, 5'd5, 0, 32'h1234_5678, 32'h0, 2'b00, 0, 2'd0, 32'h1234_5678);
        acc = last_acc_cyc;
        idle();
        #1;
        check("t2_busy", bus_if.busy, 1);
        check("t2_n0_reg_write", bus_if.reg_write, 0);
        @(negedge clk); #1;
        check("t2_n1_rw", bus_if.rw, 5);
        check("t2_n1_busw", bus_if.busw, 32'h1234_5678);
        check("t2_n1_reg_write", bus_if.reg_write, 0);
        @(negedge clk); #1;
        check("t2_n2_reg_write", bus_if.reg_write, 1);
        check("t2_latency", strobe_cyc[strobe_cyc.size()-1], acc + 2);
        @(negedge clk); #1;
        check("t2_n3_reg_write", bus_if.reg_write, 0);
        wait_idle();

        // Load lane selection and extension
        send(1, 5'd10, 1, 32'hDEAD_BEEF, 32'h80FF_7F01, 2'b10, 0, 2'd3, 32'hFFFF_FF80);
        send(1, 5'd11, 1, 32'hDEAD_BEEF, 32'h80FF_7F01, 2'b01, 1, 2'd2, 32'h0000_80FF);
        send(1, 5'd12, 1, 32'hDEAD_BEEF, 32'h80FF_7F01, 2'b10, 0, 2'd0, 32'h0000_0001);
        send(1, 5'd13, 1, 32'hDEAD_BEEF, 32'h80FF_7F01, 2'b11, 0, 2'd1, 32'h80FF_7F01);
        send(1, 5'd14, 1, 32'hDEAD_BEEF, 32'h80FF_7F01, 2'b01, 0, 2'd3, 32'hFFFF_80FF);
        send(1, 5'd15, 1, 32'hDEAD_BEEF, 32'h80FF_7F01, 2'b01, 0, 2'd1, 32'h0000_7F01);
        send(1, 5'd16, 1, 32'hDEAD_BEEF, 32'h80FF_7F01, 2'b10, 1, 2'd1, 32'h0000_007F);
        idle();
        wait_idle();
        check("t3_sb_empty", sb.size(), 0);

        // Back-to-back beats: queue fills after two, strobes 2 cycles apart
        n0 = strobe_cyc.size();
        send(1, 5'd1, 0, 32'h0000_0101, 32'h0, 2'b00, 0, 2'd0, 32'h0000_0101);
        send(1, 5'd2, 0, 32'h0000_0102, 32'h0, 2'b00, 0, 2'd0, 32'h0000_0102);
        check("t4_in_ready_full", bus_if.in_ready, 0);
        send(1, 5'd3, 0, 32'h0000_0103, 32'h0, 2'b00, 0, 2'd0, 32'h0000_0103);
        send(1, 5'd4, 0, 32'h0000_0104, 32'h0, 2'b00, 0, 2'd0, 32'h0000_0104);
        idle();
        wait_idle();
        n = strobe_cyc.size();
        check("t4_strobe_count", n - n0, 4);
        check("t4_sb_empty", sb.size(), 0);
        if (n - n0 == 4) begin
            for (int i = n0 + 1; i < n; i++)
                check("t4_spacing", strobe_cyc[i] - strobe_cyc[i-1], 2);
        end

        // Query: youngest of two pending writes to r7 wins
        send(1, 5'd7, 0, 32'h0000_000A, 32'h0, 2'b00, 0, 2'd0, 32'h0000_000A);
        send(1, 5'd7, 0, 32'h0000_000B, 32'h0, 2'b00, 0, 2'd0, 32'h0000_000B);
        bus_if.q_reg = 5'd7;
        #1;
        check("t5_q_hit", bus_if.q_hit, 1);
        check("t5_q_data", bus_if.q_data, 32'h0000_000B);
        bus_if.q_reg = 5'd3;
        #1;
        check("t5_miss_hit", bus_if.q_hit, 0);
        check("t5_miss_data", bus_if.q_data, 0);
        idle();
        wait_idle();
        bus_if.q_reg = 5'd7;
        #1;
        check("t5_drained_hit", bus_if.q_hit, 0);
        check("t5_drained_data", bus_if.q_data, 0);

        // r0 writes are queued like any other and can hit the lookup
        send(1, 5'd0, 0, 32'h0000_0055, 32'h0, 2'b00, 0, 2'd0, 32'h0000_0055);
        bus_if.q_reg = 5'd0;
        #1;
        check("t5_r0_hit", bus_if.q_hit, 1);
        check("t5_r0_data", bus_if.q_data, 32'h0000_0055);
        idle();
        wait_idle();

        // wb_en=0: consumed, nothing queued, no strobe
        n0 = strobe_cyc.size();
        send(0, 5'd9, 0, 32'hCAFE_F00D, 32'h0, 2'b00, 0, 2'd0, 32'h0);
        idle();
        #1;
        check("t6_busy", bus_if.busy, 0);
        check("t6_in_ready", bus_if.in_ready, 1);
        repeat (4) @(negedge clk);
        #1;
        check("t6_busy_later", bus_if.busy, 0);
        check("t6_no_strobe", strobe_cyc.size() - n0, 0);

        // Reset in the middle of a strobe drops reg_write immediately
        send(1, 5'd9, 0, 32'h0000_0099, 32'h0, 2'b00, 0, 2'd0, 32'h0000_0099);
        idle();
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(posedge clk);
            #1;
            if (bus_if.reg_write) seen = 1;
        end
        check("t1_strobe_seen", bus_if.reg_write, 1);
        #2 reset = 1'b1;
        #1;
        check("t1_reg_write", bus_if.reg_write, 0);
        check("t1_busy", bus_if.busy, 0);
        check("t1_in_ready", bus_if.in_ready, 1);
        check("t1_rw", bus_if.rw, 0);
        check("t1_busw", bus_if.busw, 0);
        sb.delete();
        @(negedge clk);
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("t1_busy_after", bus_if.busy, 0);
        check("t1_reg_write_after", bus_if.reg_write, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
